sram_arb_2p: RTL and testbench
==============================

SRAM_ARB_2P -- requirements
Module: sram_arb_2p

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the SRAM word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, giving the SRAM address width; depth is 1<<ADDR_WIDTH.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset: clk0 (input, 1, rising-edge clock) and rst0 (input, 1, reset).
REQ-004 The module SHALL provide, per requester n in {0,1}, the following ports:
- mn_valid, input, 1: request valid.
- mn_ready, output, 1: request accepted this cycle.
- mn_we, input, 1: 1 = write, 0 = read.
- mn_addr, input, ADDR_WIDTH: word address.
- mn_wdata, input, DATA_WIDTH: write data.
- mn_rvalid, output, 1: read data valid; one-cycle pulse.
- mn_rdata, output, DATA_WIDTH: read data.
REQ-005 The module SHALL provide these SRAM-side ports:
- csb0, output, 1: active-low chip select.
- web0, output, 1: active-low write enable.
- addr0, output, ADDR_WIDTH: SRAM address.
- din0, output, DATA_WIDTH: SRAM write data.
- dout0, input, DATA_WIDTH: SRAM read data.
- init_done, output, 1: high once clearing is complete.

Function
REQ-006 All outputs SHALL be registered; mn_ready SHALL be the only combinational output, decoded from state, mn_valid and the priority pointer.
REQ-007 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT.
REQ-008 INIT behaviour:
- Drive csb0=0, web0=0, din0=0, addr0=cnt with a 5-bit counter starting at 0, one word per cycle.
- After addr0=31 has been driven, go to RUN and set init_done=1.
- Both mn_ready SHALL be 0 throughout INIT.
REQ-009 In RUN, each cycle at most one request SHALL be granted (mn_valid & mn_ready); the transfer completes on that clock edge.
REQ-010 Grant rules:
- Exactly one requester valid: that requester is granted.
- Both valid: the requester indicated by a 1-bit round-robin pointer is granted; after the grant the pointer points to the other requester.
- No requester valid: the pointer holds.
REQ-011 On a grant at edge c, csb0/web0/addr0/din0 SHALL present the request after edge c: web0=~we, din0=wdata for writes, din0 holds its previous value for reads.
REQ-012 With no grant at edge c, csb0=1 and web0=1 SHALL be driven after edge c; addr0 and din0 hold.
REQ-013 A read granted at edge c SHALL capture dout0 at edge c+2. The granted requester's mn_rvalid SHALL be 1 for exactly the cycle after edge c+2, with mn_rdata = the captured word.
REQ-014 Read latency tracking:
- Fixed read latency of 2 cycles, tracked by a 2-stage pipeline of {valid, requester id}.
- Back-to-back reads SHALL give back-to-back responses in grant order.
- mn_rdata SHALL hold its value between pulses.
REQ-015 Writes SHALL produce no response.
REQ-016 A write at edge c followed by a read of the same address at edge c+1, from either requester, SHALL return the new data.
REQ-017 There is no response backpressure; requesters SHALL accept mn_rvalid unconditionally.
REQ-018 Out-of-range addresses cannot occur (full address decode); the INIT counter SHALL wrap to 0 only on the exit to RUN.

Reset
REQ-019 rst0 sampled high SHALL force the following values, overriding any in-flight operation:
- state=INIT, cnt=0, pointer=0, both pipeline stages invalid.
- csb0=1, web0=1, addr0=0, din0=0.
- m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, init_done=0.
REQ-020 Reads in flight at reset SHALL be discarded: no mn_rvalid pulse after reset except for requests granted after the next INIT completes.
REQ-021 The first mn_ready SHALL be possible in the 33rd cycle after the first edge with rst0 low.

Configuration
REQ-022 The macro SRAM_ARB_FIXED_PRIO_EN SHALL select the arbitration policy:
- Defined: requester 0 always wins when both are valid; the pointer is not implemented.
- Undefined: round-robin per REQ-010.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then idle 40 cycles -> csb0 low for exactly 32 cycles with addr0 0..31 and web0=0; init_done=1 from cycle 33; a read of any address returns 0x00000000.
- m0 writes 0xDEADBEEF to addr 5, then m1 reads addr 5 the next cycle -> m1_rvalid pulses 2 cycles after the m1 grant with m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- Both valid for 4 cycles, reading addrs 1,2 (m0) and 3,4 (m1) -> grants alternate m0,m1,m0,m1 (round-robin) and responses arrive in that order on consecutive cycles; with SRAM_ARB_FIXED_PRIO_EN, m0 takes both grants first.
- Two consecutive m0 reads of addr 7 then 8, holding 0x11 and 0x22 -> m0_rvalid high 2 consecutive cycles with rdata 0x11, then 0x22.
- rst0 asserted one cycle after an m1 read grant -> no m1_rvalid pulse; INIT restarts at addr0=0.
- Grant cycle during INIT with m0_valid=1 -> m0_ready=0 and no SRAM write is issued from m0.

Source files
------------

// File: rtl/sram_arb_2p.sv
`default_nettype none
// sram_arb_2p: two-requester arbiter for a single-port SRAM with power-on clear (rev 1.0).
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed m0 priority; round-robin otherwise.
module sram_arb_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  init_done
);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d, init_done_q, init_done_d;
  logic                  p1_vld_q, p1_vld_d, p1_id_q, p1_id_d, p2_vld_q, p2_id_q;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  m0_win, grant, gnt_id, gnt_we;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign m0_win = 1'b1;
`else
  logic ptr_q;
  assign m0_win = ~ptr_q;

  // Pointer always names the requester that did not win the last grant.
  always_ff @(posedge clk0) begin
    if (rst0)       ptr_q <= 1'b0;
    else if (grant) ptr_q <= ~gnt_id;
  end
`endif

  assign m0_ready  = (state_q == RUN) & m0_valid & (~m1_valid | m0_win);
  assign m1_ready  = (state_q == RUN) & m1_valid & (~m0_valid | ~m0_win);
  assign grant     = m0_ready | m1_ready;
  assign gnt_id    = m1_ready;
  assign gnt_we    = m1_ready ? m1_we    : m0_we;
  assign gnt_addr  = m1_ready ? m1_addr  : m0_addr;
  assign gnt_wdata = m1_ready ? m1_wdata : m0_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    init_done_d = init_done_q;
    p1_vld_d    = grant & ~gnt_we;
    p1_id_d     = gnt_id;
    rvalid0_d   = p2_vld_q & ~p2_id_q;
    rvalid1_d   = p2_vld_q & p2_id_q;
    rdata0_d    = rvalid0_d ? dout0 : rdata0_q;
    rdata1_d    = rvalid1_d ? dout0 : rdata1_q;
    case (state_q)
      INIT: begin
        // Leave one edge after the last word has been presented to the SRAM.
        if (!csb0_q && (addr0_q == '1)) begin
          state_d     = RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          din0_d  = '0;
          addr0_d = cnt_q;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (grant) begin
          csb0_d  = 1'b0;
          web0_d  = ~gnt_we;
          addr0_d = gnt_addr;
          if (gnt_we) din0_d = gnt_wdata;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      init_done_q <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_id_q     <= 1'b0;
      p2_vld_q    <= 1'b0;
      p2_id_q     <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      init_done_q <= init_done_d;
      p1_vld_q    <= p1_vld_d;
      p1_id_q     <= p1_id_d;
      p2_vld_q    <= p1_vld_q;
      p2_id_q     <= p1_id_q;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;
  assign init_done = init_done_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_2p.sv
`default_nettype none
// tb_sram_arb_2p: directed scenarios plus randomized traffic checked against a memory/queue model.
module tb_sram_arb_2p;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int N     = 400;

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          m0_valid = 1'b0, m0_we = 1'b0, m1_valid = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          csb0, web0, init_done;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;
  logic          prefill = 1'b1;

  int vectors    = 0;
  int miscompares = 0;

  sram_arb_2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0(clk0), .rst0(rst0),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .init_done(init_done)
  );

  always #5 clk0 = ~clk0;

  // Synchronous SRAM: request sampled at an edge, read data valid after that edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk0) begin
    if (prefill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0 <= mem[addr0];
    end
  end

  task automatic idle_inputs();
    m0_valid = 1'b0; m1_valid = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
  endtask

  task automatic reset_and_init();
    idle_inputs();
    rst0 = 1'b1;
    repeat (2) @(negedge clk0);
    rst0 = 1'b0;
    repeat (33) @(negedge clk0);
  endtask

  task automatic test_reset();
    bit            e_init;
    logic [AW-1:0] e_addr;
    rst0 = 1'b1;
    m1_valid = 1'b0;
    m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 5'd3; m0_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk0);
    #1;
    vectors++;
    if ({csb0, web0, init_done, m0_rvalid, m1_rvalid, m0_ready, m1_ready} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want %b",
               {csb0, web0, init_done, m0_rvalid, m1_rvalid, m0_ready, m1_ready}, 7'b1100000);
    end
    vectors++;
    if (addr0 !== '0 || din0 !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got addr0=%h din0=%h rd0=%h rd1=%h want all zero",
               addr0, din0, m0_rdata, m1_rdata);
    end
    @(negedge clk0);
    rst0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk0);
      if (k == 33) m0_we = 1'b0;
      if (k == 34) m0_valid = 1'b0;
      #1;
      e_init = (k <= 32);
      e_addr = e_init ? AW'(k - 1) : ((k == 33) ? 5'd31 : 5'd3);
      vectors++;
      if ({csb0, web0} !== {!(e_init || k == 34), !e_init}) begin
        miscompares++;
        $display("FAIL init_csb_web k=%0d: got %b%b want %b%b", k, csb0, web0,
                 !(e_init || k == 34), !e_init);
      end
      vectors++;
      if (addr0 !== e_addr || din0 !== '0) begin
        miscompares++;
        $display("FAIL init_addr_din k=%0d: got %0d/%h want %0d/0", k, addr0, din0, e_addr);
      end
      vectors++;
      if (init_done !== !e_init) begin
        miscompares++;
        $display("FAIL init_done k=%0d: got %b want %b", k, init_done, !e_init);
      end
      vectors++;
      if (m0_ready !== (k == 33) || m1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL init_ready k=%0d: got %b%b want %b0", k, m0_ready, m1_ready, (k == 33));
      end
      vectors++;
      if (m0_rvalid !== (k == 36) || m1_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL init_rvalid k=%0d: got %b%b want %b0", k, m0_rvalid, m1_rvalid, (k == 36));
      end
      if (k == 36) begin
        vectors++;
        if (m0_rdata !== '0) begin
          miscompares++;
          $display("FAIL cleared_read: got %h want 00000000", m0_rdata);
        end
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk0);
    m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 5'd5; m0_wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_grant: got %b%b want 10", m0_ready, m1_ready);
    end
    @(negedge clk0);
    m0_valid = 1'b0; m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 5'd5;
    #1;
    vectors++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_grant: got %b%b want 01", m0_ready, m1_ready);
    end
    vectors++;
    if ({csb0, web0} !== 2'b00 || addr0 !== 5'd5 || din0 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wr_present: got %b%b a=%0d d=%h want 00 a=5 d=deadbeef", csb0, web0, addr0, din0);
    end
    for (int d = 0; d <= 4; d++) begin
      @(negedge clk0);
      if (d == 0) m1_valid = 1'b0;
      #1;
      if (d == 0) begin
        vectors++;
        if ({csb0, web0} !== 2'b01 || addr0 !== 5'd5 || din0 !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL rd_present: got %b%b a=%0d d=%h want 01 a=5 d=deadbeef", csb0, web0, addr0, din0);
        end
      end
      vectors++;
      if (m1_rvalid !== (d == 2) || m0_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_rd_rvalid d=%0d: got %b%b want 0%b", d, m0_rvalid, m1_rvalid, (d == 2));
      end
      if (d == 2) begin
        vectors++;
        if (m1_rdata !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL wr_rd_data: got %h want deadbeef", m1_rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id [4];
    int exp_addr [4];
    int n0, n1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 1, 1}; exp_addr = '{1, 2, 3, 4};
`else
    exp_id = '{0, 1, 0, 1}; exp_addr = '{1, 3, 2, 4};
`endif
    reset_and_init();
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk0);
      m0_valid = (a != 4); m1_valid = (a == 4);
      m0_we = 1'b1; m1_we = 1'b1;
      m0_addr = AW'(a); m1_addr = AW'(a);
      m0_wdata = 32'h100 + 32'(a); m1_wdata = 32'h100 + 32'(a);
    end
    n0 = 0; n1 = 0;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk0);
      m0_we = 1'b0; m1_we = 1'b0;
      m0_valid = (it < 4) && (n0 < 2); m0_addr = AW'(1 + n0);
      m1_valid = (it < 4) && (n1 < 2); m1_addr = AW'(3 + n1);
      #1;
      vectors++;
      if (m0_ready !== (it < 4 && exp_id[it % 4] == 0) || m1_ready !== (it < 4 && exp_id[it % 4] == 1)) begin
        miscompares++;
        $display("FAIL rr_grant it=%0d: got %b%b want %b%b", it, m0_ready, m1_ready,
                 (it < 4 && exp_id[it % 4] == 0), (it < 4 && exp_id[it % 4] == 1));
      end
      if (it < 4) begin
        if (exp_id[it] == 0) n0++; else n1++;
      end
      vectors++;
      if (m0_rvalid !== (it >= 3 && it <= 6 && exp_id[(it + 1) % 4] == 0) ||
          m1_rvalid !== (it >= 3 && it <= 6 && exp_id[(it + 1) % 4] == 1)) begin
        miscompares++;
        $display("FAIL rr_rvalid it=%0d: got %b%b", it, m0_rvalid, m1_rvalid);
      end
      if (it >= 3 && it <= 6) begin
        vectors++;
        if ((exp_id[it - 3] == 0 ? m0_rdata : m1_rdata) !== 32'h100 + 32'(exp_addr[it - 3])) begin
          miscompares++;
          $display("FAIL rr_rdata it=%0d: got %h want %h", it,
                   (exp_id[it - 3] == 0 ? m0_rdata : m1_rdata), 32'h100 + 32'(exp_addr[it - 3]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      @(negedge clk0);
      m0_valid = (it < 4);
      m0_we    = (it < 2);
      m0_addr  = (it % 2 == 0) ? 5'd7 : 5'd8;
      m0_wdata = (it % 2 == 0) ? 32'h11 : 32'h22;
      #1;
      vectors++;
      if (m0_ready !== (it < 4)) begin
        miscompares++;
        $display("FAIL b2b_ready it=%0d: got %b want %b", it, m0_ready, (it < 4));
      end
      vectors++;
      if (m0_rvalid !== (it == 5 || it == 6) || m1_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_rvalid it=%0d: got %b%b want %b0", it, m0_rvalid, m1_rvalid, (it == 5 || it == 6));
      end
      if (it >= 5) begin
        vectors++;
        if (m0_rdata !== ((it == 5) ? 32'h11 : 32'h22)) begin
          miscompares++;
          $display("FAIL b2b_rdata it=%0d: got %h want %h", it, m0_rdata, ((it == 5) ? 32'h11 : 32'h22));
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk0);
    m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 5'd4;
    #1;
    vectors++;
    if (m1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flight_grant: got %b want 1", m1_ready);
    end
    @(negedge clk0);
    m1_valid = 1'b0;
    rst0 = 1'b1;
    @(negedge clk0);
    #1;
    vectors++;
    if ({csb0, web0, init_done, m0_rvalid, m1_rvalid} !== 5'b11000 || addr0 !== '0 || din0 !== '0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      miscompares++;
      $display("FAIL flight_reset: got ctl=%b a=%0d d=%h rd0=%h rd1=%h want 11000 and zeros",
               {csb0, web0, init_done, m0_rvalid, m1_rvalid}, addr0, din0, m0_rdata, m1_rdata);
    end
    @(negedge clk0);
    rst0 = 1'b0;
    #1;
    vectors++;
    if (m1_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL flight_rvalid_rst: got %b want 0", m1_rvalid);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk0);
      #1;
      vectors++;
      if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || csb0 !== 1'b0 || addr0 !== AW'(k - 1)) begin
        miscompares++;
        $display("FAIL flight_restart k=%0d: got rv=%b%b csb=%b a=%0d want rv=00 csb=0 a=%0d",
                 k, m0_rvalid, m1_rvalid, csb0, addr0, k - 1);
      end
    end
  endtask

  task automatic test_random();
    resp_t         q[$];
    resp_t         r;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last0, last1, d0, d1;
    logic [AW-1:0] a0, a1;
    bit            ptr, v0, v1, we0, we1, g0, g1, e_rv0, e_rv1, m0_first;
    reset_and_init();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last0 = '0; last1 = '0; ptr = 1'b0;
    for (int t = 0; t < N + 4; t++) begin
      @(negedge clk0);
      v0  = (t < N) && ($urandom_range(0, 3) != 0);
      v1  = (t < N) && ($urandom_range(0, 3) != 0);
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 1) == 1);
      a0  = AW'($urandom_range(0, 7));
      a1  = AW'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
      m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      m0_first = 1'b1;
`else
      m0_first = !ptr;
`endif
      g0 = v0 && (!v1 || m0_first);
      g1 = v1 && (!v0 || !m0_first);
      #1;
      vectors++;
      if (m0_ready !== g0 || m1_ready !== g1) begin
        miscompares++;
        $display("FAIL rand_ready t=%0d: got %b%b want %b%b", t, m0_ready, m1_ready, g0, g1);
      end
      e_rv0 = 1'b0; e_rv1 = 1'b0;
      if (q.size() != 0 && q[0].due == t) begin
        r = q.pop_front();
        if (r.id) begin e_rv1 = 1'b1; last1 = r.data; end
        else      begin e_rv0 = 1'b1; last0 = r.data; end
      end
      vectors++;
      if (m0_rvalid !== e_rv0 || m1_rvalid !== e_rv1) begin
        miscompares++;
        $display("FAIL rand_rvalid t=%0d: got %b%b want %b%b", t, m0_rvalid, m1_rvalid, e_rv0, e_rv1);
      end
      vectors++;
      if (m0_rdata !== last0 || m1_rdata !== last1) begin
        miscompares++;
        $display("FAIL rand_rdata t=%0d: got %h/%h want %h/%h", t, m0_rdata, m1_rdata, last0, last1);
      end
      if (g0 || g1) begin
        if (g1 ? we1 : we0) begin
          ref_mem[g1 ? a1 : a0] = g1 ? d1 : d0;
        end else begin
          r.due  = t + 3;
          r.id   = g1;
          r.data = ref_mem[g1 ? a1 : a0];
          q.push_back(r);
        end
        ptr = !g1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk0);
    prefill = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
